// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Two-port arbiter/sequencer for the single-ported data memory.
// Port 0 is the pipeline M stage, port 1 a secondary master (bridge/DMA).
// One access is in flight at a time. Writes ack in the issue cycle; reads
// ack two cycles later with the captured word.
// Optional build macro DM_ARB_PERF_EN adds saturating grant/conflict counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; winner's attributes latched on exit
// ISSUE   | memory strobe active; write acks here
// CAPTURE | memory read data valid, loaded into the winner's rdata
// RESP    | read ack pulse
module dm_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic [31:0]       m0_rdata,
  output logic              m0_ack,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic [31:0]       m1_rdata,
  output logic              m1_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
`ifdef DM_ARB_PERF_EN
  output logic [15:0]       perf_gnt0,
  output logic [15:0]       perf_gnt1,
  output logic [15:0]       perf_conflict,
`endif
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state, state_d;
  logic              last_grant, last_grant_d;
  logic              win, win_we, any_req, both_req;
  logic              mem_en_d, mem_we_d, m0_ack_d, m1_ack_d, grant_d;
  logic [3:0]        mem_be_d;
  logic [ADDR_W-3:0] mem_addr_d;
  logic [31:0]       mem_wdata_d, m0_rdata_d, m1_rdata_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W], m0_addr[1:0],
                              m1_addr[31:ADDR_W], m1_addr[1:0]};

  assign m0_stall = m0_req & ~m0_ack;
  assign busy     = (state != IDLE);

  // Pick the winner among the current requests.
  always_comb begin
    any_req  = m0_req | m1_req;
    both_req = m0_req & m1_req;
    if (both_req) win = PRIO_FIXED ? 1'b0 : ~last_grant;
    else          win = m1_req;
    win_we = win ? m1_we : m0_we;
  end

  // State register plus the registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      grant_id   <= grant_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_be     <= mem_be_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      m0_ack     <= m0_ack_d;
      m1_ack     <= m1_ack_d;
      m0_rdata   <= m0_rdata_d;
      m1_rdata   <= m1_rdata_d;
    end
  end

  // Next-state logic; in ISSUE the registered mem_we still holds the access type.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = mem_we ? IDLE : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    last_grant_d = last_grant;
    grant_d      = grant_id;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_be_d     = mem_be;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata;
    m1_rdata_d   = m1_rdata;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_d      = win;
          last_grant_d = win;
          mem_en_d     = 1'b1;
          mem_we_d     = win_we;
          mem_be_d     = win ? m1_be : m0_be;
          mem_addr_d   = win ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2];
          mem_wdata_d  = win ? m1_wdata : m0_wdata;
          if (win_we) begin
            m0_ack_d = ~win;
            m1_ack_d = win;
          end
        end
      end
      CAPTURE: begin
        if (grant_id) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = mem_rdata;
        end else begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

`ifdef DM_ARB_PERF_EN
  // Saturating performance counters; grant counts move with the ack edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      perf_gnt0     <= '0;
      perf_gnt1     <= '0;
      perf_conflict <= '0;
    end else begin
      if (m0_ack_d && perf_gnt0 != 16'hFFFF) perf_gnt0 <= perf_gnt0 + 16'd1;
      if (m1_ack_d && perf_gnt1 != 16'hFFFF) perf_gnt1 <= perf_gnt1 + 16'd1;
      if (state == IDLE && both_req && perf_conflict != 16'hFFFF)
        perf_conflict <= perf_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [31:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic        m0_ack, m1_ack, m0_stall, mem_en, mem_we, busy, grant_id;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;

  logic        f0_req = 0, f1_req = 0;
  logic [31:0] f0_addr = 0, f1_addr = 32'h40, f_zero = 0;
  logic [31:0] f0_rdata, f1_rdata, f_mem_wdata;
  logic        f0_ack, f1_ack, f0_stall, f_mem_en, f_mem_we, f_busy, f_grant;
  logic [3:0]  f_mem_be;
  logic [9:0]  f_mem_addr;

`ifdef DM_ARB_PERF_EN
  logic [15:0] perf_gnt0, perf_gnt1, perf_conflict;
  logic [15:0] f_pg0, f_pg1, f_pc;
`endif

  dm_port_arbiter #(.ADDR_W(12), .PRIO_FIXED(1'b0)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DM_ARB_PERF_EN
    .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict),
`endif
    .busy(busy), .grant_id(grant_id)
  );

  dm_port_arbiter #(.ADDR_W(12), .PRIO_FIXED(1'b1)) u_fix (
    .Clk(Clk), .Reset(Reset),
    .m0_req(f0_req), .m0_we(1'b1), .m0_be(4'hF), .m0_addr(f0_addr),
    .m0_wdata(32'h11111111), .m0_rdata(f0_rdata), .m0_ack(f0_ack), .m0_stall(f0_stall),
    .m1_req(f1_req), .m1_we(1'b1), .m1_be(4'hF), .m1_addr(f1_addr),
    .m1_wdata(32'h22222222), .m1_rdata(f1_rdata), .m1_ack(f1_ack),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_be(f_mem_be), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_zero),
`ifdef DM_ARB_PERF_EN
    .perf_gnt0(f_pg0), .perf_gnt1(f_pg1), .perf_conflict(f_pc),
`endif
    .busy(f_busy), .grant_id(f_grant)
  );

  int total = 0, passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Synchronous RAM standing in for the data memory.
  logic [31:0] ram    [0:1023];
  logic [31:0] refmem [0:1023];
  always @(posedge Clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Transaction-level model: a busy countdown per granted access.
  int          cnt;
  bit          mlast, mg, pend_rd, w;
  bit          e_en, e_we, e_a0, e_a1;
  logic [3:0]  e_be;
  logic [9:0]  e_addr;
  logic [31:0] e_wd, e_rd0, e_rd1, pend, wa, wd;
  logic [3:0]  wb;
  int          pg0, pg1, pc;
  bit          check_en = 0;

  initial forever begin
    @(negedge Clk);
    if (Reset && check_en) begin
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_be", mem_be, e_be);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("m0_ack", m0_ack, e_a0);
      chk("m1_ack", m1_ack, e_a1);
      chk("m0_rdata", m0_rdata, e_rd0);
      chk("m1_rdata", m1_rdata, e_rd1);
      chk("m0_stall", m0_stall, m0_req & ~e_a0);
      chk("busy", busy, cnt != 0);
      chk("grant_id", grant_id, mg);
`ifdef DM_ARB_PERF_EN
      chk("perf_gnt0", perf_gnt0, pg0);
      chk("perf_gnt1", perf_gnt1, pg1);
      chk("perf_conflict", perf_conflict, pc);
`endif
    end
    if (!Reset) begin
      cnt = 0; mlast = 1; mg = 0; pend_rd = 0;
      e_en = 0; e_we = 0; e_a0 = 0; e_a1 = 0;
      e_be = 0; e_addr = 0; e_wd = 0; e_rd0 = 0; e_rd1 = 0;
      pg0 = 0; pg1 = 0; pc = 0;
    end else begin
      e_en = 0; e_we = 0; e_a0 = 0; e_a1 = 0;
      if (cnt == 0) begin
        if (m0_req && m1_req && pc < 16'hFFFF) pc++;
        if (m0_req || m1_req) begin
          w = (m0_req && m1_req) ? !mlast : m1_req;
          mlast = w; mg = w;
          wa = w ? m1_addr : m0_addr;
          wb = w ? m1_be : m0_be;
          wd = w ? m1_wdata : m0_wdata;
          e_en = 1; e_we = w ? m1_we : m0_we;
          e_be = wb; e_addr = wa[11:2]; e_wd = wd;
          if (e_we) begin
            for (int b = 0; b < 4; b++)
              if (wb[b]) refmem[wa[11:2]][8*b +: 8] = wd[8*b +: 8];
            if (w) begin e_a1 = 1; if (pg1 < 16'hFFFF) pg1++; end
            else   begin e_a0 = 1; if (pg0 < 16'hFFFF) pg0++; end
            cnt = 1; pend_rd = 0;
          end else begin
            pend = refmem[wa[11:2]];
            cnt = 3; pend_rd = 1;
          end
        end
      end else begin
        cnt--;
        if (cnt == 1 && pend_rd) begin
          if (mg) begin e_a1 = 1; e_rd1 = pend; if (pg1 < 16'hFFFF) pg1++; end
          else    begin e_a0 = 1; e_rd0 = pend; if (pg0 < 16'hFFFF) pg0++; end
        end
      end
    end
  end

  task automatic nxt();
    @(posedge Clk); #1;
  endtask

  int          ack_port [4];
  int          ack_at   [4];
  int          n, c0, c1;
  logic        a0, a1;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = (i * 32'h01000193) ^ 32'h5A5A0000;
      refmem[i] = ram[i];
    end
    ram[4] = 32'hDEADBEEF; refmem[4] = 32'hDEADBEEF;

    // Reset values
    repeat (2) @(negedge Clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);
    chk("rst_addr", mem_addr, 0);
    check_en = 1;
    nxt(); Reset = 1;

    // 1: m0 read of 0x10
    m0_req = 1; m0_we = 0; m0_be = 4'hF; m0_addr = 32'h10;
    @(negedge Clk); chk("t1_stall_T", m0_stall, 1);
    nxt(); @(negedge Clk);
    chk("t1_en", mem_en, 1); chk("t1_we", mem_we, 0); chk("t1_addr", mem_addr, 4);
    chk("t1_stall_T1", m0_stall, 1);
    nxt(); @(negedge Clk); chk("t1_stall_T2", m0_stall, 1); chk("t1_noack", m0_ack, 0);
    nxt(); @(negedge Clk);
    chk("t1_ack", m0_ack, 1); chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_stall_T3", m0_stall, 0);
    nxt(); m0_req = 0;

    // 2: m1 write to 0x2C
    m1_req = 1; m1_we = 1; m1_be = 4'b0011; m1_addr = 32'h2C; m1_wdata = 32'h1234;
    nxt(); @(negedge Clk);
    chk("t2_en", mem_en, 1); chk("t2_we", mem_we, 1); chk("t2_be", mem_be, 4'b0011);
    chk("t2_addr", mem_addr, 10'hB); chk("t2_wdata", mem_wdata, 32'h1234);
    chk("t2_m1_ack", m1_ack, 1); chk("t2_m0_ack", m0_ack, 0);
    nxt(); m1_req = 0;
    repeat (2) nxt();

    // 3: round-robin with continuous reads on both ports
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h2C;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge Clk);
      if (m0_ack || m1_ack) begin
        ack_port[n] = m1_ack ? 1 : 0; ack_at[n] = k; n++;
      end
    end
    nxt(); m0_req = 0; m1_req = 0;
    chk("t3_nacks", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", (i < n) ? ack_port[i] : -1, i % 2);
      if (i > 0) chk("t3_spacing", (i < n) ? ack_at[i] - ack_at[i-1] : -1, 4);
    end
    chk("t3_first_ack", (n > 0) ? ack_at[0] : -1, 3);
    repeat (4) nxt();

    // 5: reset in CAPTURE of an m0 read
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    nxt();
    @(posedge Clk); #2;
    Reset = 0; m0_req = 0;
    #1;
    chk("t5_en", mem_en, 0); chk("t5_acks", {m0_ack, m1_ack}, 0); chk("t5_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("t5_no_ack", m0_ack, 0); chk("t5_rdata", m0_rdata, 0);
    end
    nxt(); Reset = 1;
    m1_req = 1; m1_we = 1; m1_be = 4'hF; m1_addr = 32'h0; m1_wdata = 32'hCAFE0001;
    nxt(); @(negedge Clk);
    chk("t5_m1_ack", m1_ack, 1); chk("t5_we", mem_we, 1); chk("t5_addr", mem_addr, 0);
    nxt(); m1_req = 0;
    repeat (2) nxt();

    // Randomized traffic; attributes held until ack
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk); a0 = m0_ack; a1 = m1_ack;
      nxt();
      if (!m0_req || a0) begin
        m0_req = ($urandom_range(0, 3) != 0); m0_we = $urandom_range(0, 1);
        m0_be = $urandom_range(0, 15); m0_addr = $urandom; m0_wdata = $urandom;
      end
      if (!m1_req || a1) begin
        m1_req = ($urandom_range(0, 3) != 0); m1_we = $urandom_range(0, 1);
        m1_be = $urandom_range(0, 15); m1_addr = $urandom; m1_wdata = $urandom;
      end
    end
    @(negedge Clk); a0 = m0_ack; a1 = m1_ack;
    nxt();
    if (a0 || !busy) m0_req = 0;
    if (a1 || !busy) m1_req = 0;
    for (int k = 0; k < 8 && (m0_req || m1_req); k++) begin
      @(negedge Clk); a0 = m0_ack; a1 = m1_ack;
      nxt();
      if (a0) m0_req = 0;
      if (a1) m1_req = 0;
    end
    m0_req = 0; m1_req = 0;
    repeat (6) nxt();
    chk("rand_idle", busy, 0);

    // 4: fixed priority, both ports writing continuously
    f0_req = 1; f1_req = 1; c0 = 0; c1 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (f0_ack) c0++;
      if (f1_ack) c1++;
    end
    nxt(); f0_req = 0; f1_req = 0;
    chk("t4_m0_acks", c0, 10);
    chk("t4_m1_acks", c1, 0);
    chk("t4_grant", f_grant, 0);

    repeat (2) nxt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
Two-requester arbiter and sequencer for the single-ported, word-wide data memory with byte enables. Port 0 is the pipeline M stage; port 1 is a secondary master (bridge/DMA). The block picks one request at a time, drives the memory port, captures read data, and returns a one-cycle ack. It also provides a stall output that freezes the pipeline while an M-stage access is outstanding.

Parameters:
ADDR_W, 12, byte-address bits decoded by memory; mem_addr = addr[ADDR_W-1:2]
PRIO_FIXED, 0, 0 = round-robin; 1 = port 0 always wins ties

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
m0_req  in  1  port 0 request; held with attributes until m0_ack
m0_we  in  1  1 = write, 0 = read
m0_be  in  4  byte enables for writes
m0_addr  in  32  byte address
m0_wdata  in  32  write data
m0_rdata  out  32  read data; valid in ack cycle, held until next read ack
m0_ack  out  1  one-cycle completion pulse
m0_stall  out  1  m0_req & ~m0_ack
m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_rdata, m1_ack  same as port 0
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_be  out  4  byte enables to memory
mem_addr  out  ADDR_W-2  word index
mem_wdata  out  32  write data to memory
mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_we=0
busy  out  1  state != IDLE
grant_id  out  1  port currently owning the memory

Behaviour:
- States: IDLE, ISSUE, CAPTURE, RESP. All outputs are registered except m*_stall and busy.
- IDLE: if any req is high, latch the winner's we/be/addr/wdata and grant_id, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: mem_en=1 and mem_* are driven from the latched values.
  - Write: mem_we=1 and the winner's ack=1 in this cycle; next state IDLE.
  - Read: mem_we=0; next state CAPTURE.
- CAPTURE: register mem_rdata; next state RESP.
- RESP: winner's ack=1 and the winner's rdata is updated with the captured word; next state IDLE.
- Latency from req sampled in IDLE at cycle T: write ack at T+1; read ack at T+3. Minimum spacing between grants: 2 cycles (write), 4 cycles (read).
- A req still high in the IDLE cycle after ack is treated as a new request.
- Arbitration: last_grant resets to 1, so port 0 wins the first tie.
  - PRIO_FIXED=0: on a tie, grant the port not granted last.
  - PRIO_FIXED=1: on a tie, port 0 always wins.
  - A single requester always wins.
- Outside ISSUE, mem_en and mem_we are 0; the other mem_* outputs hold their last values.
- be=0 on a write: the access is still issued with mem_we=1, memory is unchanged, and ack is returned normally.
- No alignment checking; addr[1:0] is ignored.
- req dropped before ack is a protocol violation: the granted access still completes and ack still pulses.
- Reset low (asynchronous, at any time including mid-access):
  - State → IDLE; all registered outputs → 0; last_grant → 1.
  - The in-flight access is dropped with no ack; m*_rdata → 0.

Optional Feature:
DM_ARB_PERF_EN:
- Defined: adds outputs perf_gnt0[15:0], perf_gnt1[15:0] and perf_conflict[15:0], all saturating at 0xFFFF.
  - perf_gnt0 / perf_gnt1 increment on each ack for that port.
  - perf_conflict increments on each IDLE cycle with both reqs high.
  - All three clear on reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. m0 read addr 0x10, mem_rdata=0xDEADBEEF → T+1: mem_en=1, mem_we=0, mem_addr=0x4; T+3: m0_ack=1, m0_rdata=0xDEADBEEF; m0_stall high T..T+2.
2. m1 write addr 0x2C, be=4'b0011, wdata=0x00001234 → T+1: mem_en=1, mem_we=1, mem_be=0011, mem_addr=0xB, mem_wdata=0x1234, m1_ack=1; m0_ack stays 0.
3. PRIO_FIXED=0, both ports hold continuous reads after reset → grant order 0,1,0,1 (grant_id alternates); each ack lands 4 cycles after the previous one.
4. PRIO_FIXED=1, both ports hold continuous writes for 10 grants → all 10 acks go to m0; m1_ack never asserts and m1 is starved.
5. Reset asserted during CAPTURE of an m0 read → mem_en, acks and busy = 0 immediately, no m0_ack afterward; after release, an m1 write to 0x0 acks at T+1.
6. DM_ARB_PERF_EN defined, 3 simultaneous-request IDLE cycles → perf_conflict=3; preload perf_gnt0 at 0xFFFF, one more m0 ack → still 0xFFFF.
